// File: rtl/right_up_fifo_writer.sv
// Splits a 123-pixel border burst: first UP_LEN pixels to the Up FIFO, the rest to the Right FIFO.
// Optional stall watchdog enabled by defining RIGHT_UP_WR_TIMEOUT_EN.
//   state   | meaning
//   S_IDLE  | waiting for an in_sof beat
//   S_UP    | routing beats to the Up FIFO
//   S_RIGHT | routing beats to the Right FIFO
module right_up_fifo_writer #(
    parameter int UP_LEN    = 78,
    parameter int RIGHT_LEN = 45,
    parameter int TIMEOUT   = 6000
) (
    input  logic        clk_200MHz,
    input  logic        resetn,
    input  logic        in_valid,
    input  logic        in_sof,
    input  logic [23:0] in_data,
    input  logic        full_up,
    input  logic        full_right,
    output logic        wr_en_up,
    output logic [23:0] din_up,
    output logic        wr_en_right,
    output logic [23:0] din_right,
    output logic        busy,
    output logic        burst_done,
    output logic        err_overflow,
    output logic        err_short,
    output logic        err_timeout
);

    typedef enum logic [1:0] {S_IDLE, S_UP, S_RIGHT} state_t;

    localparam logic [6:0] LAST_UP  = 7'(UP_LEN - 1);
    localparam logic [6:0] LAST_PIX = 7'(UP_LEN + RIGHT_LEN - 1);

    state_t     state;
    logic [6:0] pix_cnt;
    logic       done_pend;
    logic       timeout_hit;

`ifdef RIGHT_UP_WR_TIMEOUT_EN
    localparam logic [12:0] LAST_IDLE = 13'(TIMEOUT - 1);
    logic [12:0] idle_cnt;

    assign timeout_hit = (state != S_IDLE) && !in_valid && (idle_cnt == LAST_IDLE);

    always_ff @(posedge clk_200MHz or negedge resetn) begin
        if (!resetn) begin
            idle_cnt    <= '0;
            err_timeout <= 1'b0;
        end else begin
            err_timeout <= timeout_hit;
            if (state == S_IDLE || in_valid || timeout_hit)
                idle_cnt <= '0;
            else
                idle_cnt <= idle_cnt + 13'd1;
        end
    end
`else
    assign timeout_hit = 1'b0;
    assign err_timeout = 1'b0;
`endif

    always_ff @(posedge clk_200MHz or negedge resetn) begin
        if (!resetn) begin
            state        <= S_IDLE;
            pix_cnt      <= '0;
            done_pend    <= 1'b0;
            wr_en_up     <= 1'b0;
            din_up       <= '0;
            wr_en_right  <= 1'b0;
            din_right    <= '0;
            busy         <= 1'b0;
            burst_done   <= 1'b0;
            err_overflow <= 1'b0;
            err_short    <= 1'b0;
        end else begin
            wr_en_up    <= 1'b0;
            wr_en_right <= 1'b0;
            burst_done  <= 1'b0;
            err_short   <= 1'b0;
            done_pend   <= 1'b0;

            // busy is held one extra cycle so it drops together with burst_done
            if (done_pend) begin
                burst_done <= 1'b1;
                busy       <= 1'b0;
            end

            if (in_valid && in_sof) begin
                if (state != S_IDLE)
                    err_short <= 1'b1;
                if (full_up) begin
                    err_overflow <= 1'b1;
                end else begin
                    wr_en_up <= 1'b1;
                    din_up   <= in_data;
                end
                pix_cnt <= 7'd1;
                state   <= S_UP;
                busy    <= 1'b1;
            end else if (in_valid) begin
                case (state)
                    S_UP: begin
                        if (full_up) begin
                            err_overflow <= 1'b1;
                        end else begin
                            wr_en_up <= 1'b1;
                            din_up   <= in_data;
                        end
                        pix_cnt <= pix_cnt + 7'd1;
                        if (pix_cnt == LAST_UP)
                            state <= S_RIGHT;
                    end
                    S_RIGHT: begin
                        if (full_right) begin
                            err_overflow <= 1'b1;
                        end else begin
                            wr_en_right <= 1'b1;
                            din_right   <= in_data;
                        end
                        if (pix_cnt == LAST_PIX) begin
                            state     <= S_IDLE;
                            pix_cnt   <= '0;
                            done_pend <= 1'b1;
                        end else begin
                            pix_cnt <= pix_cnt + 7'd1;
                        end
                    end
                    default: ;
                endcase
            end else if (timeout_hit) begin
                state   <= S_IDLE;
                pix_cnt <= '0;
                busy    <= 1'b0;
            end
        end
    end

endmodule

// File: doc/right_up_fifo_writer.md
# right_up_fifo_writer

Write-side counterpart of the right/up border FIFO pair. Accepts a 123-pixel border burst on a valid-qualified 24-bit RGB stream in the clk_200MHz domain and splits it: the first 78 pixels go to the Up FIFO, the remaining 45 go to the Right FIFO. The order matches the order in which the read side drains them. The block also tracks burst framing, FIFO overflow and stalled bursts.

## Interface
Parameters:
- UP_LEN, 78, pixels per burst routed to Up FIFO
- RIGHT_LEN, 45, pixels per burst routed to Right FIFO
- TIMEOUT, 6000, max idle clk_200MHz cycles between beats inside a burst (30 us)

Ports:
- clk_200MHz  input  1  system clock; all logic on rising edge
- resetn  input  1  reset, asynchronous, active-low
- in_valid  input  1  pixel beat valid
- in_sof  input  1  start-of-burst marker; qualified by in_valid
- in_data  input  24  RGB pixel {R,G,B}
- full_up  input  1  Up FIFO full
- full_right  input  1  Right FIFO full
- wr_en_up  output  1  Up FIFO write strobe
- din_up  output  24  Up FIFO write data
- wr_en_right  output  1  Right FIFO write strobe
- din_right  output  24  Right FIFO write data
- busy  output  1  burst in progress (state != IDLE)
- burst_done  output  1  one-cycle pulse after last pixel of a complete burst
- err_overflow  output  1  sticky; a beat was dropped due to full FIFO
- err_short  output  1  one-cycle pulse; burst aborted by early in_sof
- err_timeout  output  1  one-cycle pulse; burst aborted by timeout

## Operation
- Pixel counter pix_cnt: 7 bits, range 0..UP_LEN+RIGHT_LEN-1 (0..122). Increments by exactly 1 per accepted beat and never wraps within a burst.
- FSM states:
  - IDLE: beats without in_sof are ignored. A beat with in_valid & in_sof is pixel 0; it is written to the Up FIFO, pix_cnt=1, and the FSM goes to UP.
  - UP: each valid beat goes to the Up FIFO. The beat carrying pix_cnt==UP_LEN-1 moves the FSM to RIGHT.
  - RIGHT: each valid beat goes to the Right FIFO. The beat carrying pix_cnt==122 returns the FSM to IDLE and pulses burst_done next cycle.
- Full handling:
  - A beat arriving while the target FIFO is full is not written: wr_en stays 0.
  - err_overflow sets and stays set until reset.
  - pix_cnt still advances, so routing stays aligned with the reader's 78/45 split.
- Early in_sof: if in UP or RIGHT and a beat with in_sof arrives:
  - Pulse err_short.
  - Treat that beat as pixel 0 of a new burst (write to Up, pix_cnt=1, go to UP).
  - burst_done is not pulsed for the aborted burst.
- in_sof on the final pixel of a burst is treated as an early in_sof (err_short, restart), not as completion.
- Routing is decided by pix_cnt, never by FIFO state. wr_en_up and wr_en_right are never high in the same cycle.

## Timing
- Reset values: wr_en_up=0, wr_en_right=0, din_up=0, din_right=0, busy=0, burst_done=0, err_overflow=0, err_short=0, err_timeout=0; FSM=IDLE, pix_cnt=0, idle counter=0.
- Outputs are registered; latency is 1 cycle from beat to wr_en/din.
  - din_* update only on a write, otherwise hold.
- full_* is sampled in the same cycle as in_valid. The FIFO must assert full with at least one free entry of margin; this block does not predict full.
- Back-to-back beats are supported at 1 pixel/cycle. Best case, a burst occupies 123 cycles and burst_done follows 1 cycle after the last wr_en_right.
- busy rises the cycle after the sof beat and falls in the same cycle burst_done rises.
- If resetn is asserted mid-burst, all state clears immediately and asynchronously. The partial burst is abandoned; the FIFOs are not flushed by this block.

## Configuration
- Macro RIGHT_UP_WR_TIMEOUT_EN.
- Defined:
  - A 13-bit idle counter runs in UP and RIGHT, clears on every valid beat, and clears in IDLE.
  - When it reaches TIMEOUT, the FSM goes to IDLE, pix_cnt clears, and err_timeout pulses for one cycle.
  - The next beat without in_sof is ignored.
- Undefined:
  - No counter; err_timeout is tied 0.
  - The FSM waits indefinitely for the remaining beats.

## Test plan
- Reset, then 123 back-to-back beats (sof on first) with data=index → 78 wr_en_up with din_up 0..77, then 45 wr_en_right with din_right 78..122; burst_done pulses once; busy low afterwards.
- Same burst with full_up held high for beats 10–12 → 75 Up writes (10,11,12 missing), Right still gets exactly 78..122, err_overflow=1 and stays 1.
- 50 beats, then a new sof beat, then 123 beats → err_short pulses once; no burst_done for the first burst; second burst routes 78/45 correctly.
- RIGHT_UP_WR_TIMEOUT_EN defined: 100 beats, then 6000 idle cycles → err_timeout pulses, busy drops; 10 following non-sof beats produce no writes.
- Assert resetn low at beat 90, release, send a full burst → all outputs 0 during reset; the new burst routes 78/45 with no error flags.
- Random in_valid gaps (<TIMEOUT) across a burst → same write counts and data as the back-to-back case; wr_en_up and wr_en_right never both high.
